fram_arbiter: RTL

Two-port arbiter that shares the single SPI FRAM controller between requesters, e.g. port 0 = instruction fetch and port 1 = data load/store. It latches a winning request, pulses the controller's start, tracks the controller's ready through busy and done, and returns read data plus a one-cycle acknowledge to the granted port. It sits between the CPU-side memory interfaces and the FRAM controller.

---
 rtl/fram_arbiter.sv | 139 +++++++++++++
 1 files changed

// File: rtl/fram_arbiter.sv
// fram_arbiter: shares one SPI FRAM controller between two requesters.
// Port 0 is typically instruction fetch, port 1 data load/store.
// Optional feature macro: FRAM_ARB_RR_EN selects round-robin arbitration;
// when undefined, port 0 has fixed priority and no pointer register exists.
module fram_arbiter #(
  parameter int unsigned ADDR_WIDTH = 24
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0,
  input  logic                  req1,
  input  logic                  write0,
  input  logic                  write1,
  input  logic                  word0,
  input  logic                  word1,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [15:0]           wdata0,
  input  logic [15:0]           wdata1,
  output logic                  ack0,
  output logic                  ack1,
  output logic [15:0]           rdata0,
  output logic [15:0]           rdata1,
  output logic                  fram_start,
  output logic                  fram_write,
  output logic                  fram_word,
  output logic [23:0]           fram_addr,
  output logic [15:0]           fram_wdata,
  input  logic                  fram_ready,
  input  logic [15:0]           fram_rdata
);

  typedef enum logic [1:0] {StIdle, StIssue, StWaitBusy, StWaitDone} state_e;

  state_e state_q;
  logic   grant_q;
  logic   pick;

  logic [23:0] addr0_ext;
  logic [23:0] addr1_ext;

  assign addr0_ext = 24'(addr0);
  assign addr1_ext = 24'(addr1);

`ifdef FRAM_ARB_RR_EN
  logic last_q;

  // Round-robin winner: on contention the port not granted last wins.
  always_comb begin
    pick = req1;
    if (req0 && req1) begin
      pick = ~last_q;
    end
  end
`else
  // Fixed priority winner: port 0 whenever it is requesting.
  always_comb begin
    pick = ~req0;
  end
`endif

  // Arbiter FSM with registered command, start, ack and read-data outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      grant_q    <= 1'b0;
      fram_start <= 1'b0;
      ack0       <= 1'b0;
      ack1       <= 1'b0;
      rdata0     <= 16'h0000;
      rdata1     <= 16'h0000;
      fram_write <= 1'b0;
      fram_word  <= 1'b0;
      fram_addr  <= 24'h000000;
      fram_wdata <= 16'h0000;
`ifdef FRAM_ARB_RR_EN
      last_q     <= 1'b1;
`endif
    end else begin
      fram_start <= 1'b0;
      ack0       <= 1'b0;
      ack1       <= 1'b0;
      unique case (state_q)
        StIdle: begin
          // The acked requester still holds req during its ack cycle, so no
          // grant is made then; otherwise the finished transfer would repeat.
          if (fram_ready && (req0 || req1) && !ack0 && !ack1) begin
            grant_q    <= pick;
            fram_write <= pick ? write1 : write0;
            fram_word  <= pick ? word1 : word0;
            fram_addr  <= pick ? addr1_ext : addr0_ext;
            fram_wdata <= pick ? wdata1 : wdata0;
            fram_start <= 1'b1;
            state_q    <= StIssue;
`ifdef FRAM_ARB_RR_EN
            last_q     <= pick;
`endif
          end
        end
        StIssue: begin
          state_q <= StWaitBusy;
        end
        StWaitBusy: begin
          if (!fram_ready) begin
            state_q <= StWaitDone;
          end
        end
        StWaitDone: begin
          if (fram_ready) begin
            state_q <= StIdle;
            if (grant_q) begin
              ack1 <= 1'b1;
              if (!fram_write) begin
                if (fram_word) begin
                  rdata1 <= fram_rdata;
                end else begin
                  rdata1[7:0] <= fram_rdata[7:0];
                end
              end
            end else begin
              ack0 <= 1'b1;
              if (!fram_write) begin
                if (fram_word) begin
                  rdata0 <= fram_rdata;
                end else begin
                  rdata0[7:0] <= fram_rdata[7:0];
                end
              end
            end
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule
